// File: rtl/reduction_accumulator_if.sv
// ============================================================================
// Module      : reduction_accumulator_if
// Description : Flit-in / reduced-flit-out handshake bundle of the reduction
//               accumulator.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface reduction_accumulator_if #(
    parameter int FLIT_SIZE = 82,
    parameter int CNT_W     = 3
);
    logic [FLIT_SIZE-1:0] in;
    logic                 in_valid;
    logic                 in_ready;
    logic [CNT_W-1:0]     expected_cnt;
    logic [1:0]           op;
    logic [FLIT_SIZE-1:0] out;
    logic                 out_valid;
    logic                 out_ready;
    logic                 out_ovf;
    logic                 busy;

    modport master (
        output in, in_valid, expected_cnt, op, out_ready,
        input  in_ready, out, out_valid, out_ovf, busy
    );

    modport slave (
        input  in, in_valid, expected_cnt, op, out_ready,
        output in_ready, out, out_valid, out_ovf, busy
    );
endinterface

`default_nettype wire

// File: rtl/reduction_accumulator.sv
// ============================================================================
// Module      : reduction_accumulator
// Description : Combines the data fields of N flits with sum/max/min/or and
//               emits one reduced flit carrying the first flit's header.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module reduction_accumulator #(
    parameter int FLIT_SIZE = 82,
    parameter int DATA_W    = 32,
    parameter int CNT_W     = 3
) (
    input  wire logic              clk,
    input  wire logic              rst,
    reduction_accumulator_if.slave bus
);

    localparam int c_HDR_W = FLIT_SIZE - DATA_W;

    localparam logic [1:0] c_ST_IDLE  = 2'd0;
    localparam logic [1:0] c_ST_ACCUM = 2'd1;
    localparam logic [1:0] c_ST_SEND  = 2'd2;

    localparam logic [1:0] c_OP_SUM = 2'd0;
    localparam logic [1:0] c_OP_MAX = 2'd1;
    localparam logic [1:0] c_OP_MIN = 2'd2;
    localparam logic [1:0] c_OP_OR  = 2'd3;

    localparam logic [CNT_W-1:0] c_CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    logic [1:0]           r_state;
    logic [DATA_W-1:0]    r_acc;
    logic [c_HDR_W-1:0]   r_hdr;
    logic [CNT_W-1:0]     r_cnt;
    logic [CNT_W-1:0]     r_exp;
    logic [1:0]           r_op;
    logic                 r_ovf;
    logic [FLIT_SIZE-1:0] r_out;
    logic                 r_out_valid;
    logic                 r_out_ovf;
    logic                 r_busy;

    logic                 w_in_ready;
    logic                 w_accept;
    logic [DATA_W-1:0]    w_din;
    logic [c_HDR_W-1:0]   w_hdr_in;
    logic [DATA_W-1:0]    w_sum;
    logic                 w_step_ovf;
    logic [DATA_W-1:0]    w_acc_nxt;
    logic                 w_ovf_nxt;
    logic [CNT_W-1:0]     w_cnt_nxt;
    logic [CNT_W-1:0]     w_exp_eff;

    // Ready drops with reset itself, not only with the registered state.
    assign w_in_ready = rst && (r_state != c_ST_SEND);
    assign w_accept   = bus.in_valid && w_in_ready;
    assign w_din      = bus.in[DATA_W-1:0];
    assign w_hdr_in   = bus.in[FLIT_SIZE-1:DATA_W];
    assign w_sum      = r_acc + w_din;
    assign w_step_ovf = (r_acc[DATA_W-1] == w_din[DATA_W-1]) &&
                        (w_sum[DATA_W-1] != r_acc[DATA_W-1]);
    assign w_cnt_nxt  = r_cnt + c_CNT_ONE;
    assign w_exp_eff  = (bus.expected_cnt == '0) ? c_CNT_ONE : bus.expected_cnt;

    always_comb begin
        w_acc_nxt = r_acc;
        w_ovf_nxt = r_ovf;
        case (r_op)
            c_OP_SUM: begin
                w_acc_nxt = w_sum;
                w_ovf_nxt = r_ovf | w_step_ovf;
            end
            c_OP_MAX: w_acc_nxt = ($signed(w_din) > $signed(r_acc)) ? w_din : r_acc;
            c_OP_MIN: w_acc_nxt = ($signed(w_din) < $signed(r_acc)) ? w_din : r_acc;
            c_OP_OR:  w_acc_nxt = r_acc | w_din;
            default:  w_acc_nxt = r_acc;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state     <= c_ST_IDLE;
            r_acc       <= '0;
            r_hdr       <= '0;
            r_cnt       <= '0;
            r_exp       <= '0;
            r_op        <= '0;
            r_ovf       <= 1'b0;
            r_out       <= '0;
            r_out_valid <= 1'b0;
            r_out_ovf   <= 1'b0;
            r_busy      <= 1'b0;
        end else begin
            case (r_state)
                c_ST_IDLE: begin
                    if (w_accept) begin
                        r_acc  <= w_din;
                        r_hdr  <= w_hdr_in;
                        r_op   <= bus.op;
                        r_ovf  <= 1'b0;
                        r_cnt  <= c_CNT_ONE;
                        r_exp  <= w_exp_eff;
                        r_busy <= 1'b1;
                        if (w_exp_eff == c_CNT_ONE) begin
                            r_state     <= c_ST_SEND;
                            r_out       <= bus.in;
                            r_out_valid <= 1'b1;
                            r_out_ovf   <= 1'b0;
                        end else begin
                            r_state <= c_ST_ACCUM;
                        end
                    end
                end
                c_ST_ACCUM: begin
                    if (w_accept) begin
                        r_acc <= w_acc_nxt;
                        r_ovf <= w_ovf_nxt;
                        r_cnt <= w_cnt_nxt;
                        // Result is registered on the last accept so it is visible next cycle.
                        if (w_cnt_nxt == r_exp) begin
                            r_state     <= c_ST_SEND;
                            r_out       <= {r_hdr, w_acc_nxt};
                            r_out_valid <= 1'b1;
                            r_out_ovf   <= (r_op == c_OP_SUM) ? w_ovf_nxt : 1'b0;
                        end
                    end
                end
                c_ST_SEND: begin
                    if (bus.out_ready) begin
                        r_state     <= c_ST_IDLE;
                        r_out       <= '0;
                        r_out_valid <= 1'b0;
                        r_out_ovf   <= 1'b0;
                        r_busy      <= 1'b0;
                    end
                end
                default: r_state <= c_ST_IDLE;
            endcase
        end
    end

    assign bus.in_ready  = w_in_ready;
    assign bus.out       = r_out;
    assign bus.out_valid = r_out_valid;
    assign bus.out_ovf   = r_out_ovf;
    assign bus.busy      = r_busy;

endmodule

`default_nettype wire

// File: tb/tb_reduction_accumulator.sv
// ============================================================================
// Module      : tb_reduction_accumulator
// Description : Directed bench with a list-based reduction model and a
//               per-cycle output compare.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_reduction_accumulator;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    reduction_accumulator_if #(.FLIT_SIZE(82), .CNT_W(3)) bus ();

    reduction_accumulator #(.FLIT_SIZE(82), .DATA_W(32), .CNT_W(3)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int asserts = 0;
    int fails   = 0;

    task automatic chk(input string name, input logic [81:0] act, input logic [81:0] req);
        asserts++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s: got %h, required %h", name, act, req);
        end
    endtask

    // Whole-list reduction: operands combined in arrival order, int arithmetic.
    function automatic void do_reduce(input logic [1:0] o, input logic [31:0] v[$],
                                      output logic [31:0] r, output logic f);
        int     a;
        int     b;
        longint s;
        f = 1'b0;
        a = int'(v[0]);
        for (int i = 1; i < v.size(); i++) begin
            b = int'(v[i]);
            case (o)
                2'd0: begin
                    s = longint'(a) + longint'(b);
                    if (s > 64'sd2147483647 || s < -64'sd2147483648) f = 1'b1;
                    a = int'(s);
                end
                2'd1: if (b > a) a = b;
                2'd2: if (b < a) a = b;
                default: a = a | b;
            endcase
        end
        r = a;
    endfunction

    typedef struct {
        logic [81:0] flit;
        logic        ovf;
    } res_t;

    res_t        q[$];
    logic [31:0] m_vals[$];
    bit          m_active = 1'b0;
    int          m_exp    = 0;
    logic [1:0]  m_op     = '0;
    logic [49:0] m_hdr    = '0;

    int          res_count = 0;
    logic [81:0] last_out  = '0;
    logic        last_ovf  = 1'b0;

    always @(negedge clk) begin
        logic [31:0] r;
        logic        f;
        if (!rst) begin
            chk("rst_out_valid", bus.out_valid, 0);
            chk("rst_busy", bus.busy, 0);
            chk("rst_in_ready", bus.in_ready, 0);
            chk("rst_out", bus.out, 0);
            chk("rst_out_ovf", bus.out_ovf, 0);
            q.delete();
            m_vals.delete();
            m_active = 1'b0;
        end else begin
            chk("out_valid", bus.out_valid, q.size() != 0);
            chk("in_ready", bus.in_ready, q.size() == 0);
            chk("busy", bus.busy, m_active || q.size() != 0);
            if (q.size() != 0) begin
                chk("out", bus.out, q[0].flit);
                chk("out_ovf", bus.out_ovf, q[0].ovf);
            end else begin
                chk("out_idle", bus.out, 0);
            end
            if (q.size() != 0 && bus.out_ready) begin
                last_out = bus.out;
                last_ovf = bus.out_ovf;
                void'(q.pop_front());
                res_count++;
            end else if (q.size() == 0 && bus.in_valid) begin
                if (!m_active) begin
                    m_hdr = bus.in[81:32];
                    m_op  = bus.op;
                    m_exp = (bus.expected_cnt == 3'd0) ? 1 : int'(bus.expected_cnt);
                    m_vals.delete();
                end
                m_vals.push_back(bus.in[31:0]);
                m_active = 1'b1;
                if (m_vals.size() == m_exp) begin
                    do_reduce(m_op, m_vals, r, f);
                    q.push_back('{flit: {m_hdr, r}, ovf: f});
                    m_active = 1'b0;
                end
            end
        end
    end

    task automatic push(input logic [49:0] h, input logic [31:0] d,
                        input logic [2:0] e, input logic [1:0] o);
        int n = 0;
        bus.in           = {h, d};
        bus.in_valid     = 1'b1;
        bus.expected_cnt = e;
        bus.op           = o;
        @(negedge clk);
        while (!bus.in_ready && n < 200) begin
            n++;
            @(negedge clk);
        end
        if (!bus.in_ready) chk("accept_timeout", 0, 1);
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
    endtask

    int want = 0;

    task automatic wait_res();
        int n = 0;
        want++;
        while (res_count < want && n < 200) begin
            @(posedge clk);
            n++;
        end
        #1;
        chk("result_timeout", res_count >= want, 1);
        res_count = want;
    endtask

    initial begin
        logic [81:0] held;
        bus.in           = '0;
        bus.in_valid     = 1'b0;
        bus.expected_cnt = '0;
        bus.op           = '0;
        bus.out_ready    = 1'b1;
        #2;
        chk("init_out_valid", bus.out_valid, 0);
        chk("init_in_ready", bus.in_ready, 0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;

        // Sum 5 + 7 + (-2); later flits carry different op/count which must be ignored
        push(50'h1AB, 32'd5, 3'd3, 2'd0);
        push(50'h3FF, 32'd7, 3'd5, 2'd3);
        push(50'h3FF, 32'hFFFF_FFFE, 3'd5, 2'd1);
        wait_res();
        chk("sum_data", last_out[31:0], 32'h0000_000A);
        chk("sum_hdr", last_out[81:32], 50'h1AB);
        chk("sum_ovf", last_ovf, 0);

        push(50'h2, 32'h7FFF_FFFF, 3'd2, 2'd0);
        push(50'h2, 32'h1, 3'd2, 2'd0);
        wait_res();
        chk("ovf_data", last_out[31:0], 32'h8000_0000);
        chk("ovf_flag", last_ovf, 1);
        push(50'h3, 32'h1, 3'd2, 2'd0);
        push(50'h3, 32'h1, 3'd2, 2'd0);
        wait_res();
        chk("ovf_clear_data", last_out[31:0], 32'h2);
        chk("ovf_clear_flag", last_ovf, 0);

        for (int o = 1; o <= 3; o++) begin
            push(50'h10, 32'hFFFF_FFFD, 3'd4, 2'(o));
            push(50'h10, 32'd9, 3'd4, 2'(o));
            push(50'h10, 32'h8000_0000, 3'd4, 2'(o));
            push(50'h10, 32'd2, 3'd4, 2'(o));
            wait_res();
            case (o)
                1: chk("max_data", last_out[31:0], 32'h0000_0009);
                2: chk("min_data", last_out[31:0], 32'h8000_0000);
                default: chk("or_data", last_out[31:0], 32'hFFFF_FFFF);
            endcase
            chk("minmax_ovf", last_ovf, 0);
        end

        // Backpressure: result held while a new flit waits upstream
        bus.out_ready = 1'b0;
        push(50'hAA, 32'h1234, 3'd1, 2'd0);
        held             = bus.out;
        bus.in           = {50'hBB, 32'h5678};
        bus.in_valid     = 1'b1;
        bus.expected_cnt = 3'd1;
        repeat (5) begin
            @(negedge clk);
            chk("bp_in_ready", bus.in_ready, 0);
            chk("bp_out_stable", bus.out, held);
        end
        chk("bp_held_value", held, {50'hAA, 32'h1234});
        @(posedge clk);
        #1 bus.out_ready = 1'b1;
        push(50'hBB, 32'h5678, 3'd1, 2'd0);
        wait_res();
        chk("bp_first", last_out, {50'hAA, 32'h1234});
        wait_res();
        chk("bp_second", last_out, {50'hBB, 32'h5678});

        // expected_cnt of zero behaves as one
        push(50'h5, 32'h55, 3'd0, 2'd3);
        wait_res();
        chk("exp0_data", last_out[31:0], 32'h55);

        push(50'h6, 32'd3, 3'd2, 2'd0);
        repeat (4) @(posedge clk);
        #1;
        chk("gap_busy", bus.busy, 1);
        chk("gap_no_valid", bus.out_valid, 0);
        push(50'h6, 32'd4, 3'd2, 2'd0);
        wait_res();
        chk("gap_data", last_out[31:0], 32'd7);

        // Deepest count the counter supports: 1+2+...+7
        for (int i = 1; i <= 7; i++) push(50'h7, 32'(i), 3'd7, 2'd0);
        wait_res();
        chk("cnt7_data", last_out[31:0], 32'd28);

        // Asynchronous reset mid-reduction
        push(50'h8, 32'd1, 3'd3, 2'd0);
        push(50'h8, 32'd2, 3'd3, 2'd0);
        chk("pre_rst_busy", bus.busy, 1);
        #2 rst = 1'b0;
        #1;
        chk("arst_out_valid", bus.out_valid, 0);
        chk("arst_busy", bus.busy, 0);
        chk("arst_in_ready", bus.in_ready, 0);
        @(posedge clk);
        #1 rst = 1'b1;
        push(50'h9, 32'h11, 3'd1, 2'd0);
        wait_res();
        chk("post_rst_data", last_out, {50'h9, 32'h11});

        repeat (3) @(posedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", asserts, fails);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule

`default_nettype wire
